// File: rtl/reg_write_queue_pkg.sv
// Shared constants and types for the register write queue and its bypass lookup.
package reg_write_queue_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } wr_size_e;

  // Reserved encoding behaves as a full word, so only half/byte are partial.
  function automatic logic is_partial(input logic [1:0] size);
    return (size == SZ_HALF) || (size == SZ_BYTE);
  endfunction

endpackage

// File: rtl/reg_write_queue_lookup.sv
// Age-priority bypass match over the queued write entries for one read port.
module wq_lookup
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic [REG_ADDR_W-1:0]             lk_addr_i,
  input  logic [DEPTH-1:0]                  ent_valid_i,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]      ent_data_i,
  input  logic [DEPTH-1:0][1:0]             ent_size_i,
  output logic                              hit_o,
  output logic [DATA_W-1:0]                 data_o,
  output logic                              partial_o
);

  logic              found;
  logic              found_partial;
  logic [DATA_W-1:0] found_data;

  // Entries are ordered oldest (index 0) to youngest, so a later match wins.
  always_comb begin
    found         = 1'b0;
    found_partial = 1'b0;
    found_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_i[i] && (ent_addr_i[i] == lk_addr_i) && (lk_addr_i != '0)) begin
        found         = 1'b1;
        found_partial = is_partial(ent_size_i[i]);
        found_data    = ent_data_i[i];
      end
    end
  end

  assign hit_o     = found && !found_partial;
  assign data_o    = hit_o ? found_data : '0;
  assign partial_o = found && found_partial;

endmodule

// File: rtl/reg_write_queue.sv
// In-order register write queue with combinational bypass lookup for two read ports.
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [REG_ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [1:0]              wr_size,
  input  logic                    flush,
  output logic                    rf_valid,
  input  logic                    rf_ready,
  output logic [REG_ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]       rf_data,
  output logic [1:0]              rf_size,
  input  logic [REG_ADDR_W-1:0]   lk_addr1,
  input  logic [REG_ADDR_W-1:0]   lk_addr2,
  output logic                    lk_hit1,
  output logic                    lk_hit2,
  output logic [DATA_W-1:0]       lk_data1,
  output logic [DATA_W-1:0]       lk_data2,
  output logic                    lk_stall,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [1:0]            size_q [DEPTH];

  logic accept;
  logic enqueue;
  logic retire;

  assign wr_ready = (count_q < CNT_W'(DEPTH));
  assign rf_valid = (count_q != '0);
  assign accept   = wr_valid && wr_ready;
  assign enqueue  = accept && (wr_addr != '0);
  assign retire   = rf_valid && rf_ready;
  assign count    = count_q;

  assign rf_addr = rf_valid ? addr_q[rd_ptr_q] : '0;
  assign rf_data = rf_valid ? data_q[rd_ptr_q] : '0;
  assign rf_size = rf_valid ? size_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enqueue) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (retire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enqueue, retire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: every read of it is qualified by count_q.
  always_ff @(posedge clk) begin
    if (enqueue && !flush) begin
      addr_q[wr_ptr_q] <= wr_addr;
      data_q[wr_ptr_q] <= wr_data;
      size_q[wr_ptr_q] <= wr_size;
    end
  end

  logic [DEPTH-1:0]                  ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0]      ent_data;
  logic [DEPTH-1:0][1:0]             ent_size;
  logic [PTR_W-1:0]                  age_idx;

  // Rotate the circular buffer so the lookups see entries in age order.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    ent_data  = '0;
    ent_size  = '0;
    age_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx      = rd_ptr_q + PTR_W'(i);
      ent_valid[i] = (CNT_W'(i) < count_q);
      ent_addr[i]  = addr_q[age_idx];
      ent_data[i]  = data_q[age_idx];
      ent_size[i]  = size_q[age_idx];
    end
  end

  logic partial1;
  logic partial2;

  wq_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_lookup1 (
    .lk_addr_i   (lk_addr1),
    .ent_valid_i (ent_valid),
    .ent_addr_i  (ent_addr),
    .ent_data_i  (ent_data),
    .ent_size_i  (ent_size),
    .hit_o       (lk_hit1),
    .data_o      (lk_data1),
    .partial_o   (partial1)
  );

  wq_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_lookup2 (
    .lk_addr_i   (lk_addr2),
    .ent_valid_i (ent_valid),
    .ent_addr_i  (ent_addr),
    .ent_data_i  (ent_data),
    .ent_size_i  (ent_size),
    .hit_o       (lk_hit2),
    .data_o      (lk_data2),
    .partial_o   (partial2)
  );

  assign lk_stall = partial1 || partial2;

endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed scenarios plus a randomized scoreboard run.
module tb_reg_write_queue;
  import reg_write_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        flush;
  logic        rf_valid;
  logic        rf_ready;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  rf_size;
  logic [4:0]  lk_addr1;
  logic [4:0]  lk_addr2;
  logic        lk_hit1;
  logic        lk_hit2;
  logic [31:0] lk_data1;
  logic [31:0] lk_data2;
  logic        lk_stall;
  logic [2:0]  count;

  int total;
  int bad;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  size;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] model_img [32];
  logic [31:0] dut_img   [32];

  reg_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_size  (wr_size),
    .flush    (flush),
    .rf_valid (rf_valid),
    .rf_ready (rf_ready),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .rf_size  (rf_size),
    .lk_addr1 (lk_addr1),
    .lk_addr2 (lk_addr2),
    .lk_hit1  (lk_hit1),
    .lk_hit2  (lk_hit2),
    .lk_data1 (lk_data1),
    .lk_data2 (lk_data2),
    .lk_stall (lk_stall),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_size  = SZ_WORD;
    flush    = 1'b0;
    rf_ready = 1'b0;
    lk_addr1 = '0;
    lk_addr2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Architectural effect of one retired write on a register value.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] sz);
    case (sz)
      SZ_HALF: return {old[31:16], d[15:0]};
      SZ_BYTE: return {old[31:8], d[7:0]};
      default: return d;
    endcase
  endfunction

  // Youngest queued write to the address decides: word -> bypass, partial -> stall.
  task automatic model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d,
                              output logic part);
    logic found;
    hit = 1'b0; d = '0; part = 1'b0; found = 1'b0;
    if (a != 0) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (!found && model_q[i].addr == a) begin
          found = 1'b1;
          if (model_q[i].size == SZ_HALF || model_q[i].size == SZ_BYTE) part = 1'b1;
          else begin
            hit = 1'b1;
            d   = model_q[i].data;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    total++; if (rf_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rf_valid: got %b expected 0", rf_valid); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    total++; if ({lk_hit1, lk_hit2, lk_stall} !== 3'b000) begin bad++; $display("[TB] FAIL reset_lookup: got %b expected 000", {lk_hit1, lk_hit2, lk_stall}); end
    total++; if ({rf_addr, rf_data, rf_size} !== 39'd0) begin bad++; $display("[TB] FAIL reset_rf_fields: got %h expected 0", {rf_addr, rf_data, rf_size}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    idle();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_size = SZ_WORD; rf_ready = 1'b1;
    #1;
    total++; if (rf_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_no_passthrough: got %b expected 0", rf_valid); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if (rf_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_rf_valid: got %b expected 1", rf_valid); end
    total++; if (rf_addr !== 5'd5) begin bad++; $display("[TB] FAIL single_rf_addr: got %0d expected 5", rf_addr); end
    total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_rf_data: got %h expected deadbeef", rf_data); end
    tick();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL single_count_after: got %0d expected 0", count); end
  endtask

  task automatic test_full_order();
    idle();
    for (int k = 1; k <= 5; k++) begin
      wr_valid = 1'b1; wr_addr = 5'(k); wr_data = 32'(k * 16); wr_size = SZ_WORD;
      #1;
      total++;
      if (wr_ready !== (k <= 4)) begin bad++; $display("[TB] FAIL full_wr_ready_k%0d: got %b expected %b", k, wr_ready, (k <= 4)); end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
    rf_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if ({rf_valid, rf_addr, rf_data} !== {1'b1, 5'(k), 32'(k * 16)}) begin
        bad++; $display("[TB] FAIL full_drain_order_%0d: got v=%b a=%0d d=%h expected a=%0d", k, rf_valid, rf_addr, rf_data, k);
      end
      tick();
    end
    rf_ready = 1'b0;
    #1;
    total++; if ({rf_valid, count} !== 4'b0000) begin bad++; $display("[TB] FAIL full_empty_after: got v=%b c=%0d expected empty", rf_valid, count); end
  endtask

  task automatic test_bypass();
    idle();
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11; wr_size = SZ_WORD;
    tick();
    wr_data = 32'h22;
    tick();
    wr_valid = 1'b0; lk_addr1 = 5'd7; lk_addr2 = 5'd9;
    #1;
    total++; if ({lk_hit1, lk_data1} !== {1'b1, 32'h22}) begin bad++; $display("[TB] FAIL bypass_word_hit: got %b/%h expected 1/22", lk_hit1, lk_data1); end
    total++; if ({lk_hit2, lk_data2, lk_stall} !== 34'd0) begin bad++; $display("[TB] FAIL bypass_miss_port2: got %b/%h stall=%b expected 0", lk_hit2, lk_data2, lk_stall); end
    wr_valid = 1'b1; wr_data = 32'h33; wr_size = SZ_BYTE;
    #1;
    total++; if ({lk_hit1, lk_stall} !== 2'b10) begin bad++; $display("[TB] FAIL bypass_incoming_excluded: got hit=%b stall=%b expected 1/0", lk_hit1, lk_stall); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if ({lk_stall, lk_hit1, lk_data1} !== {2'b10, 32'h0}) begin bad++; $display("[TB] FAIL bypass_partial_stall: got stall=%b hit=%b d=%h expected 1/0/0", lk_stall, lk_hit1, lk_data1); end
    lk_addr1 = 5'd0; lk_addr2 = 5'd7;
    #1;
    total++; if ({lk_stall, lk_hit2, lk_hit1} !== 3'b100) begin bad++; $display("[TB] FAIL bypass_stall_port2: got %b expected 100", {lk_stall, lk_hit2, lk_hit1}); end
    rf_ready = 1'b1;
    repeat (3) tick();
    idle();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL bypass_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFE0000; wr_size = SZ_WORD;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_wr_ready: got %b expected 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if ({count, rf_valid} !== 4'b0000) begin bad++; $display("[TB] FAIL zero_not_queued: got c=%0d v=%b expected 0/0", count, rf_valid); end
    total++; if ({lk_hit1, lk_data1} !== 33'd0) begin bad++; $display("[TB] FAIL zero_lookup: got %b/%h expected 0/0", lk_hit1, lk_data1); end
  endtask

  task automatic test_flush_and_reset();
    idle();
    for (int k = 1; k <= 4; k++) begin
      wr_valid = 1'b1; wr_addr = 5'(k); wr_data = 32'h100 + 32'(k); wr_size = SZ_WORD;
      tick();
    end
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hA; rf_ready = 1'b1;
    #1;
    total++; if ({count, wr_ready} !== 4'b1000) begin bad++; $display("[TB] FAIL flush_full_state: got c=%0d r=%b expected 4/0", count, wr_ready); end
    tick();
    #1;
    total++; if ({count, wr_ready} !== 4'b0111) begin bad++; $display("[TB] FAIL flush_retire_only: got c=%0d r=%b expected 3/1", count, wr_ready); end
    tick();
    #1;
    total++; if ({count, rf_addr} !== {3'd3, 5'd3}) begin bad++; $display("[TB] FAIL flush_accept_retire: got c=%0d a=%0d expected 3/3", count, rf_addr); end
    flush = 1'b1; wr_valid = 1'b1; wr_addr = 5'd11; rf_ready = 1'b1;
    tick();
    idle();
    #1;
    total++; if ({count, rf_valid} !== 4'b0000) begin bad++; $display("[TB] FAIL flush_empties: got c=%0d v=%b expected 0/0", count, rf_valid); end
    wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h12;
    tick();
    wr_addr = 5'd13; wr_data = 32'h13;
    tick();
    wr_valid = 1'b0; rf_ready = 1'b1;
    tick();
    #1;
    total++; if ({rf_valid, count, rf_addr} !== {1'b1, 3'd1, 5'd13}) begin bad++; $display("[TB] FAIL drain_before_reset: got v=%b c=%0d a=%0d expected 1/1/13", rf_valid, count, rf_addr); end
    rst_n = 1'b0;
    #1;
    total++; if ({rf_valid, count} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_mid_drain: got v=%b c=%0d expected 0/0", rf_valid, count); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (rf_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_pulse_%0d: got %b expected 0", k, rf_valid); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    int          accepted;
    int          cycles;
    logic        h1, h2, p1, p2, m_accept, m_retire;
    logic [31:0] d1, d2;
    ent_t        e;
    do_reset();
    model_q.delete();
    for (int r = 0; r < 32; r++) begin
      model_img[r] = '0;
      dut_img[r]   = '0;
    end
    accepted = 0;
    cycles   = 0;
    while ((accepted < 20 || model_q.size() != 0) && cycles < 400) begin
      wr_valid = (accepted < 20) && ($urandom_range(0, 3) != 0);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      wr_size  = 2'($urandom_range(0, 3));
      rf_ready = (accepted >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      lk_addr1 = 5'($urandom_range(0, 7));
      lk_addr2 = 5'($urandom_range(0, 7));
      #1;
      model_lookup(lk_addr1, h1, d1, p1);
      model_lookup(lk_addr2, h2, d2, p2);
      total++; if (count !== 3'(model_q.size())) begin bad++; $display("[TB] FAIL rand_count_c%0d: got %0d expected %0d", cycles, count, model_q.size()); end
      total++; if (wr_ready !== (model_q.size() < DEPTH)) begin bad++; $display("[TB] FAIL rand_wr_ready_c%0d: got %b", cycles, wr_ready); end
      if (model_q.size() != 0) begin
        total++;
        if ({rf_valid, rf_addr, rf_data, rf_size} !== {1'b1, model_q[0]}) begin
          bad++; $display("[TB] FAIL rand_head_c%0d: got v=%b a=%0d d=%h s=%0d expected a=%0d d=%h s=%0d", cycles, rf_valid, rf_addr, rf_data, rf_size, model_q[0].addr, model_q[0].data, model_q[0].size);
        end
      end else begin
        total++; if (rf_valid !== 1'b0) begin bad++; $display("[TB] FAIL rand_empty_c%0d: got rf_valid=%b expected 0", cycles, rf_valid); end
      end
      total++;
      if ({lk_hit1, lk_data1, lk_hit2, lk_data2, lk_stall} !== {h1, d1, h2, d2, p1 | p2}) begin
        bad++; $display("[TB] FAIL rand_lookup_c%0d: got %b/%h %b/%h st=%b expected %b/%h %b/%h st=%b", cycles, lk_hit1, lk_data1, lk_hit2, lk_data2, lk_stall, h1, d1, h2, d2, p1 | p2);
      end
      if (rf_valid && rf_ready) dut_img[rf_addr] = merge(dut_img[rf_addr], rf_data, rf_size);
      m_accept = wr_valid && (model_q.size() < DEPTH);
      m_retire = (model_q.size() != 0) && rf_ready;
      if (m_retire) begin
        e = model_q.pop_front();
        model_img[e.addr] = merge(model_img[e.addr], e.data, e.size);
      end
      if (m_accept) begin
        accepted++;
        if (wr_addr != 0) model_q.push_back('{wr_addr, wr_data, wr_size});
      end
      tick();
      cycles++;
    end
    idle();
    total++; if (cycles >= 400) begin bad++; $display("[TB] FAIL rand_timeout: got %0d cycles expected under 400", cycles); end
    for (int r = 0; r < 32; r++) begin
      total++;
      if (dut_img[r] !== model_img[r]) begin bad++; $display("[TB] FAIL rand_regfile_r%0d: got %h expected %h", r, dut_img[r], model_img[r]); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    tick();
    test_single_write();
    test_full_order();
    test_bypass();
    test_zero_reg();
    test_flush_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
